// File: rtl/switch_event_monitor.sv
// Debounces 18 switches on a sampling tick and reports the highest changed switch as one event per commit.
// Latency: stable change to EVENT_O within (DEBOUNCE_TICKS+1)*CLK_DIV+2 cycles; outputs update with the pulse.
// Backpressure: none; events are one-cycle pulses and the display always shows the latest committed event.
module switch_event_monitor #(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic             CLOCK_50_I,
    input  logic             RESETN_I,
    input  logic [17:0]      SWITCH_I,
    output logic [7:0][6:0]  SEVEN_SEGMENT_N_O,
    output logic [17:0]      LED_RED_O,
    output logic [8:0]       LED_GREEN_O,
    output logic             EVENT_O
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Active-low 7-segment pattern for a decimal digit; anything else blanks.
    function automatic logic [6:0] seg7(input logic [4:0] d);
        case (d)
            5'd0:    seg7 = 7'h40;
            5'd1:    seg7 = 7'h79;
            5'd2:    seg7 = 7'h24;
            5'd3:    seg7 = 7'h30;
            5'd4:    seg7 = 7'h19;
            5'd5:    seg7 = 7'h12;
            5'd6:    seg7 = 7'h02;
            5'd7:    seg7 = 7'h78;
            5'd8:    seg7 = 7'h00;
            5'd9:    seg7 = 7'h10;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Index of the most significant set bit; zero when nothing is set.
    function automatic logic [4:0] hi_bit(input logic [17:0] v);
        hi_bit = 5'd0;
        for (int b = 0; b < 18; b++) begin
            if (v[b]) hi_bit = 5'(b);
        end
    endfunction

    logic [17:0]   sync_meta;
    logic [17:0]   sync;
    logic [PW-1:0] presc;
    logic          tick;

    state_t        state, state_nxt;
    logic [17:0]   cand, cand_nxt;
    logic [3:0]    stable_cnt, stable_nxt;

    logic [17:0]   debounced;
    logic [4:0]    evt_idx;
    logic          evt_lvl;
    logic          evt_seen;
    logic [3:0]    cnt_ones, cnt_tens;
    logic          event_q;
    logic [7:0][6:0] seg_q;

    logic [4:0]    idx_c;
    logic [4:0]    idx_ones_c;
    logic [4:0]    idx_tens_c;
    logic          lvl_c;
    logic [3:0]    ones_c, tens_c;

    // Two-flop synchronizer for the raw asynchronous switch levels.
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= SWITCH_I;
            sync      <= sync_meta;
        end
    end

    assign tick = (presc == PW'(CLK_DIV - 1));

    // Free-running prescaler producing one sample tick every CLK_DIV cycles.
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    // Debounce FSM state, candidate vector and stability count.
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            state      <= IDLE;
            cand       <= '0;
            stable_cnt <= '0;
        end else begin
            state      <= state_nxt;
            cand       <= cand_nxt;
            stable_cnt <= stable_nxt;
        end
    end

    // Next-state logic: IDLE/SETTLE only evaluate on ticks, COMMIT is a single cycle.
    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        stable_nxt = stable_cnt;
        case (state)
            IDLE: begin
                if (tick && (sync != debounced)) begin
                    cand_nxt   = sync;
                    stable_nxt = 4'd1;
                    state_nxt  = (DEBOUNCE_TICKS <= 1) ? COMMIT : SETTLE;
                end
            end
            SETTLE: begin
                if (tick) begin
                    if (sync == cand) begin
                        stable_nxt = stable_cnt + 4'd1;
                        if ((stable_cnt + 4'd1) >= 4'(DEBOUNCE_TICKS)) state_nxt = COMMIT;
                    end else if (sync == debounced) begin
                        state_nxt = IDLE;
                    end else begin
                        cand_nxt   = sync;
                        stable_nxt = 4'd1;
                        if (DEBOUNCE_TICKS <= 1) state_nxt = COMMIT;
                    end
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Values the commit will publish: highest changed index, its new level and the next BCD count.
    always_comb begin
        idx_c      = hi_bit(cand ^ debounced);
        lvl_c      = cand[idx_c];
        idx_tens_c = (idx_c >= 5'd10) ? 5'd1 : 5'd0;
        idx_ones_c = (idx_c >= 5'd10) ? (idx_c - 5'd10) : idx_c;
        ones_c     = cnt_ones;
        tens_c     = cnt_tens;
        if (cnt_ones == 4'd9) begin
            ones_c = 4'd0;
            tens_c = (cnt_tens == 4'd9) ? 4'd0 : (cnt_tens + 4'd1);
        end else begin
            ones_c = cnt_ones + 4'd1;
        end
    end

    // Commit register bank: everything visible updates together with the event pulse.
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            debounced <= '0;
            evt_idx   <= '0;
            evt_lvl   <= 1'b0;
            evt_seen  <= 1'b0;
            cnt_ones  <= '0;
            cnt_tens  <= '0;
            event_q   <= 1'b0;
            seg_q     <= {SEG_BLANK, SEG_BLANK, SEG_BLANK,
                          7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        end else begin
            event_q <= (state == COMMIT);
            if (state == COMMIT) begin
                debounced <= cand;
                evt_idx   <= idx_c;
                evt_lvl   <= lvl_c;
                evt_seen  <= 1'b1;
                cnt_ones  <= ones_c;
                cnt_tens  <= tens_c;
                seg_q     <= {SEG_BLANK, SEG_BLANK, SEG_BLANK,
                              seg7({4'd0, lvl_c}),
                              seg7(idx_tens_c),
                              seg7(idx_ones_c),
                              seg7({1'b0, tens_c}),
                              seg7({1'b0, ones_c})};
            end
        end
    end

    assign SEVEN_SEGMENT_N_O = seg_q;
    assign LED_RED_O         = debounced;
    assign LED_GREEN_O       = {evt_seen, 3'b000, evt_idx};
    assign EVENT_O           = event_q;

endmodule

// File: doc/switch_event_monitor.md
SWITCH_EVENT_MONITOR -- requirements
Module: switch_event_monitor

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, giving the number of clock cycles per sample tick (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 3, giving the number of consecutive identical tick samples needed to accept a change (legal range 1..15).
REQ-003 SHALL have port CLOCK_50_I, input, 1 bit, the only clock; all logic is rising-edge.
REQ-004 SHALL have port RESETN_I, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port SWITCH_I, input, 18 bits, raw asynchronous switch levels.
REQ-006 SHALL have port SEVEN_SEGMENT_N_O, output, array [7:0] of 7 bits, active-low segments with bit0=a ... bit6=g.
REQ-007 SHALL have port LED_RED_O, output, 18 bits, the debounced switch vector.
REQ-008 SHALL have port LED_GREEN_O, output, 9 bits: [4:0] is the binary index of the last event, [7:5] is 0, and [8] is the event-seen flag.
REQ-009 SHALL have port EVENT_O, output, 1 bit, a one-cycle pulse for each committed event.

Function
REQ-010 SHALL pass SWITCH_I through a 2-flop synchronizer (sync) before any other use.
REQ-011 SHALL run a prescaler that counts 0..CLK_DIV-1 and wraps; tick is high for one cycle when count==CLK_DIV-1.
REQ-012 SHALL use a 3-state FSM with states IDLE, SETTLE and COMMIT; evaluation in IDLE and SETTLE happens only on tick cycles.
REQ-013 In IDLE on a tick with sync!=debounced, the FSM SHALL load cand=sync and stable_cnt=1, then go to SETTLE; otherwise it stays in IDLE.
REQ-014 In SETTLE on a tick, the FSM SHALL act on the first matching case:
- sync==cand: increment stable_cnt;
- sync==debounced: go to IDLE with no event;
- otherwise: reload cand=sync and stable_cnt=1.
REQ-015 In SETTLE, when stable_cnt reaches DEBOUNCE_TICKS, the FSM SHALL go to COMMIT; with DEBOUNCE_TICKS=1, it goes to COMMIT on the same tick that entered SETTLE.
REQ-016 COMMIT SHALL last exactly one cycle regardless of tick and then return to IDLE.
REQ-017 COMMIT SHALL set debounced=cand, and the event index SHALL be the highest set bit of (cand XOR old debounced).
REQ-018 COMMIT SHALL store the event level = cand[index], set the event-seen flag to 1, and increment the BCD event counter.
REQ-019 The event counter SHALL be two BCD digits that wrap from 99 to 00; wrap SHALL NOT clear the event-seen flag.
REQ-020 When several switches change within one commit, the block SHALL record exactly one event, using the highest changed index and incrementing the count by 1.
REQ-021 Committed results SHALL become visible on all outputs, and EVENT_O SHALL pulse high, in the cycle after COMMIT; latency from a stable sync change to EVENT_O is at most (DEBOUNCE_TICKS+1)*CLK_DIV+2 cycles.
REQ-022 SEVEN_SEGMENT_N_O SHALL be registered and display:
- digit0: count ones;
- digit1: count tens;
- digit2: index ones (decimal);
- digit3: index tens;
- digit4: event level (0/1);
- digits 5-7: blank (7'h7F).
REQ-023 Segment encoding SHALL be the standard active-low set: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
REQ-024 Changes that reverse before DEBOUNCE_TICKS stable ticks SHALL produce no event and no output change.

Reset
REQ-025 While RESETN_I=0, the block SHALL hold:
- FSM=IDLE, prescaler=0, synchronizer=0, debounced=0, cand=0, stable_cnt=0;
- counter=00, index=0, level=0, event-seen=0;
- EVENT_O=0, LED_RED_O=0, LED_GREEN_O=0;
- digits 0-4 showing 7'h40 and digits 5-7 showing 7'h7F.
REQ-026 Reset asserted in SETTLE or COMMIT SHALL abort the pending change, commit nothing, and leave no event pending after release.
REQ-027 After reset release, the first tick SHALL occur CLK_DIV cycles later.

Verification (CLK_DIV=4, DEBOUNCE_TICKS=3)
REQ-028 Single change: SWITCH_I 0 -> 18'h00001, held -> exactly one EVENT_O within 18 cycles; LED_RED_O=18'h00001, LED_GREEN_O=9'h100, digit0=7'h79, digit4=7'h79.
REQ-029 Multi-switch change: SWITCH_I 18'h00001 -> 18'h00007 in one step -> one event with index 2 and count 02; digit2=7'h24, LED_GREEN_O=9'h102.
REQ-030 Glitch: bit 17 set for 2 ticks, then cleared -> no EVENT_O and all outputs unchanged.
REQ-031 Wrap: 100 alternating toggles of bit 5 -> count 00, digits 0 and 1 = 7'h40, LED_GREEN_O[8]=1; bit 5 set to 1 on odd-numbered toggles and 0 on even-numbered toggles, so after toggle 100 bit 5 = 0, LED_RED_O=0 and digit4=7'h40.
REQ-032 Mid-operation reset: RESETN_I pulsed low during SETTLE -> all outputs at reset values and no EVENT_O for CLK_DIV cycles after release; a still-differing SWITCH_I then debounces normally.
